fifo_flex: RTL and testbench

FIFO_FLEX -- requirements
Module: fifo_flex

---
 rtl/fifo_flex.sv | 102 ++++++++++
 tb/tb_fifo_flex.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fifo_flex.sv
// Synchronous FIFO with wrap-bit pointers, optional first-word-fall-through read, level flags and sticky errors.
// Standard read data appears one cycle after an accepted read; full/empty reject requests and raise overflow/underflow.
module fifo_flex #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] head_dat;

    // Status is a pure function of the registered pointers.
    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    assign wr_acc   = wr_en && !full;
    assign rd_acc   = rd_en && !empty;
    assign head_dat = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (wr_acc) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PW'(1);
            if (FWFT == 0) begin
                dout_d       = head_dat;
                dout_valid_d = 1'b1;
            end
        end
        // A new error in the same cycle as clr_err must still be recorded.
        overflow_d  = (wr_en && full)  || (overflow_q  && !clr_err);
        underflow_d = (rd_en && empty) || (underflow_q && !clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

    assign dout       = (FWFT != 0) ? (empty ? '0 : head_dat) : dout_q;
    assign dout_valid = (FWFT != 0) ? !empty : dout_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Drives a standard-read and a FWFT instance with identical stimulus and checks both against a queue model.
module tb_fifo_flex;
    localparam int W = 8;
    localparam int D = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] din = '0;
    logic         rd_en = 1'b0;
    logic         clr_err = 1'b0;

    logic         s_full, s_af, s_dv, s_empty, s_ae, s_ovf, s_udf;
    logic [W-1:0] s_dout;
    logic [5:0]   s_count;
    logic         f_full, f_af, f_dv, f_empty, f_ae, f_ovf, f_udf;
    logic [W-1:0] f_dout;
    logic [5:0]   f_count;

    fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(s_full), .almost_full(s_af),
        .rd_en(rd_en), .dout(s_dout), .dout_valid(s_dv), .empty(s_empty), .almost_empty(s_ae),
        .count(s_count), .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err));

    fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(f_full), .almost_full(f_af),
        .rd_en(rd_en), .dout(f_dout), .dout_valid(f_dv), .empty(f_empty), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err));

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] m_dout = '0;
    logic         m_dv = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int n;
        n = q.size();
        chk({ph, " count"},  32'(s_count), 32'(n));
        chk({ph, " empty"},  32'(s_empty), 32'(n == 0));
        chk({ph, " full"},   32'(s_full),  32'(n == D));
        chk({ph, " afull"},  32'(s_af),    32'(n >= D - 2));
        chk({ph, " aempty"}, 32'(s_ae),    32'(n <= 2));
        chk({ph, " ovf"},    32'(s_ovf),   32'(m_ovf));
        chk({ph, " udf"},    32'(s_udf),   32'(m_udf));
        chk({ph, " dv"},     32'(s_dv),    32'(m_dv));
        chk({ph, " dout"},   32'(s_dout),  32'(m_dout));
        chk({ph, " f_count"}, 32'(f_count), 32'(n));
        chk({ph, " f_flags"}, {28'd0, f_full, f_empty, f_ovf, f_udf},
            {28'd0, n == D, n == 0, m_ovf, m_udf});
        chk({ph, " f_lvl"},  {30'd0, f_af, f_ae}, {30'd0, n >= D - 2, n <= 2});
        chk({ph, " f_dv"},   32'(f_dv),    32'(n != 0));
        chk({ph, " f_dout"}, 32'(f_dout),  (n != 0) ? 32'(q[0]) : 32'd0);
    endtask

    // One clock: apply request, advance the model by its rules, check just after the edge.
    task automatic cyc(input logic w, input logic [W-1:0] d, input logic r, input logic c, input string ph);
        logic wacc, racc;
        wr_en = w; din = d; rd_en = r; clr_err = c;
        @(posedge clk);
        wacc  = w && (q.size() < D);
        racc  = r && (q.size() > 0);
        m_ovf = (w && q.size() == D) || (m_ovf && !c);
        m_udf = (r && q.size() == 0) || (m_udf && !c);
        m_dv  = racc;
        if (racc) m_dout = q.pop_front();
        if (wacc) q.push_back(d);
        #1;
        check_all(ph);
    endtask

    // Reset lands between edges; outputs must clear before any clock.
    task automatic mid_reset(input string ph);
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h77;
        #2 rst = 1'b1;
        q.delete(); m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        #1 check_all({ph, " async"});
        @(posedge clk); #1 check_all({ph, " held"});
        @(negedge clk) rst = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0;
        #1 check_all({ph, " rel"});
    endtask

    initial begin
        logic [W-1:0] v;
        rst = 1'b1;
        #1 check_all("por");
        #12 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < D; i++) cyc(1'b1, W'(i), 1'b0, 1'b0, "fill");
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, "ovf");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "clr1");

        for (int i = 0; i < D; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "udf");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "hold");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "clr2");

        cyc(1'b1, 8'hA5, 1'b0, 1'b0, "fwft_wr");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "fwft_pop");

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 20; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b0, "wrap_w");
            for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "wrap_r");
        end
        for (int i = 0; i < 10; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b0, "pre10");
        for (int i = 0; i < 50; i++) cyc(1'b1, W'($urandom), 1'b1, 1'b0, "simul");

        while (q.size() < D) cyc(1'b1, W'($urandom), 1'b0, 1'b0, "refill");
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, "full_rw");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "clr3");

        for (int i = 0; i < 400; i++) begin
            v = W'($urandom);
            if (i < 200)
                cyc($urandom_range(0, 3) != 0, v, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, "rnd_up");
            else
                cyc($urandom_range(0, 3) == 0, v, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "rnd_dn");
        end

        for (int i = 0; i < 5; i++) cyc(1'b1, W'($urandom), 1'b0, 1'b0, "pre_rst");
        mid_reset("rst");
        cyc(1'b1, 8'h3C, 1'b0, 1'b0, "rt_wr");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "rt_rd");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "rt_idle");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
